// File: rtl/rgb2ycbcr_2pix.sv
// BT.601 RGB to studio-range YCbCr 4:4:4 converter, PIXCEL_NUM independent lanes per clock.
// Three register stages: products, rounded sums, shift/offset/clamp/blank.
module rgb2ycbcr_2pix #(
  parameter int BIT_PER_SYMBLE = 8,
  parameter int PIXCEL_NUM     = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [3*BIT_PER_SYMBLE*PIXCEL_NUM-1:0] rgb_din,
  input  logic [PIXCEL_NUM-1:0]                 rgb_h_sync,
  input  logic [PIXCEL_NUM-1:0]                 rgb_v_sync,
  input  logic [PIXCEL_NUM-1:0]                 rgb_de,
  output logic [3*BIT_PER_SYMBLE*PIXCEL_NUM-1:0] ycbcr_dout,
  output logic [PIXCEL_NUM-1:0]                 ycbcr_h_sync,
  output logic [PIXCEL_NUM-1:0]                 ycbcr_v_sync,
  output logic [PIXCEL_NUM-1:0]                 ycbcr_de
);
  localparam int B  = BIT_PER_SYMBLE;
  localparam int S  = B - 8;
  localparam int PW = B + 8;
  localparam int SW = B + 10;

  localparam logic signed [SW-1:0] RND    = SW'(128);
  localparam logic signed [SW-1:0] Y_OFS  = SW'(16 << S);
  localparam logic signed [SW-1:0] C_OFS  = SW'(128 << S);
  localparam logic signed [SW-1:0] Y_MAX  = SW'(235 << S);
  localparam logic signed [SW-1:0] C_MAX  = SW'(240 << S);
  localparam logic signed [SW-1:0] V_MIN  = SW'(16 << S);
  localparam logic [B-1:0]         MIN_B  = B'(16 << S);
  localparam logic [B-1:0]         YMAX_B = B'(235 << S);
  localparam logic [B-1:0]         CMAX_B = B'(240 << S);
  localparam logic [B-1:0]         BLK_C  = B'(128 << S);

  function automatic logic signed [SW-1:0] ext(input logic [PW-1:0] p);
    return $signed(SW'(p));
  endfunction

  function automatic logic [B-1:0] clamp(input logic signed [SW-1:0] v,
                                         input logic signed [SW-1:0] vmax,
                                         input logic [B-1:0] vmax_b);
    if (v < V_MIN)
      return MIN_B;
    else if (v > vmax)
      return vmax_b;
    else
      return v[B-1:0];
  endfunction

  logic [PIXCEL_NUM-1:0] h1_q, v1_q, de1_q, h2_q, v2_q, de2_q, h3_q, v3_q, de3_q;
  logic [PIXCEL_NUM-1:0] h1_d, v1_d, de1_d, h2_d, v2_d, de2_d, h3_d, v3_d, de3_d;

  always_comb begin
    h1_d  = rgb_h_sync;
    v1_d  = rgb_v_sync;
    de1_d = rgb_de;
    h2_d  = h1_q;
    v2_d  = v1_q;
    de2_d = de1_q;
    h3_d  = h2_q;
    v3_d  = v2_q;
    de3_d = de2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q <= '0; v1_q <= '0; de1_q <= '0;
      h2_q <= '0; v2_q <= '0; de2_q <= '0;
      h3_q <= '0; v3_q <= '0; de3_q <= '0;
    end else begin
      h1_q <= h1_d; v1_q <= v1_d; de1_q <= de1_d;
      h2_q <= h2_d; v2_q <= v2_d; de2_q <= de2_d;
      h3_q <= h3_d; v3_q <= v3_d; de3_q <= de3_d;
    end
  end

  assign ycbcr_h_sync = h3_q;
  assign ycbcr_v_sync = v3_q;
  assign ycbcr_de     = de3_q;

  genvar gi;
  generate
    for (gi = 0; gi < PIXCEL_NUM; gi++) begin : g_lane
      logic [B-1:0]           r, g, b;
      logic [PW-1:0]          prod_d [9];
      logic [PW-1:0]          prod_q [9];
      logic signed [SW-1:0]   y_sum_d, cb_sum_d, cr_sum_d;
      logic signed [SW-1:0]   y_sum_q, cb_sum_q, cr_sum_q;
      logic signed [SW-1:0]   y_off, cb_off, cr_off;
      logic [3*B-1:0]         dout_d, dout_q;

      assign r = rgb_din[3*B*gi + 2*B +: B];
      assign g = rgb_din[3*B*gi + B   +: B];
      assign b = rgb_din[3*B*gi       +: B];

      // Magnitudes only; the coefficient signs are applied when summing.
      always_comb begin
        prod_d[0] = PW'(r) * PW'(66);
        prod_d[1] = PW'(g) * PW'(129);
        prod_d[2] = PW'(b) * PW'(25);
        prod_d[3] = PW'(r) * PW'(38);
        prod_d[4] = PW'(g) * PW'(74);
        prod_d[5] = PW'(b) * PW'(112);
        prod_d[6] = PW'(r) * PW'(112);
        prod_d[7] = PW'(g) * PW'(94);
        prod_d[8] = PW'(b) * PW'(18);
      end

      always_comb begin
        y_sum_d  = ext(prod_q[0]) + ext(prod_q[1]) + ext(prod_q[2]) + RND;
        cb_sum_d = ext(prod_q[5]) - ext(prod_q[3]) - ext(prod_q[4]) + RND;
        cr_sum_d = ext(prod_q[6]) - ext(prod_q[7]) - ext(prod_q[8]) + RND;
      end

      always_comb begin
        y_off  = (y_sum_q  >>> 8) + Y_OFS;
        cb_off = (cb_sum_q >>> 8) + C_OFS;
        cr_off = (cr_sum_q >>> 8) + C_OFS;
        dout_d = {MIN_B, BLK_C, BLK_C};
        if (de2_q[gi])
          dout_d = {clamp(y_off, Y_MAX, YMAX_B), clamp(cb_off, C_MAX, CMAX_B),
                    clamp(cr_off, C_MAX, CMAX_B)};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < 9; i++) prod_q[i] <= '0;
          y_sum_q  <= '0;
          cb_sum_q <= '0;
          cr_sum_q <= '0;
          dout_q   <= '0;
        end else begin
          for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
          y_sum_q  <= y_sum_d;
          cb_sum_q <= cb_sum_d;
          cr_sum_q <= cr_sum_d;
          dout_q   <= dout_d;
        end
      end

      assign ycbcr_dout[3*B*gi +: 3*B] = dout_q;
    end
  endgenerate
endmodule

// File: tb/tb_rgb2ycbcr_2pix.sv
// Scoreboard bench: 8-bit and 10-bit instances driven in lockstep, checked against a
// plain-integer BT.601 model three clocks after each beat.
module tb_rgb2ycbcr_2pix;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] din8 = '0;
  logic [59:0] din10 = '0;
  logic [1:0]  h_in = '0, v_in = '0, de_in = '0;
  logic [47:0] dout8;
  logic [59:0] dout10;
  logic [1:0]  h8, v8, de8, h10, v10, de10;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [47:0] e8;
    logic [59:0] e10;
    logic [1:0]  h, v, de;
    int          due;
  } exp_t;
  exp_t sb[$];

  rgb2ycbcr_2pix #(.BIT_PER_SYMBLE(8), .PIXCEL_NUM(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .rgb_din(din8), .rgb_h_sync(h_in), .rgb_v_sync(v_in),
    .rgb_de(de_in), .ycbcr_dout(dout8), .ycbcr_h_sync(h8), .ycbcr_v_sync(v8), .ycbcr_de(de8));

  rgb2ycbcr_2pix #(.BIT_PER_SYMBLE(10), .PIXCEL_NUM(2)) dut10 (
    .clk(clk), .rst_n(rst_n), .rgb_din(din10), .rgb_h_sync(h_in), .rgb_v_sync(v_in),
    .rgb_de(de_in), .ycbcr_dout(dout10), .ycbcr_h_sync(h10), .ycbcr_v_sync(v10), .ycbcr_de(de10));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Returns {Y,Cb,Cr} as three 12-bit fields for a bw-bit symbol width.
  function automatic logic [35:0] ref_lane(input int bw, input int r, input int g,
                                           input int b, input bit de);
    int s, y, cb, cr;
    s = bw - 8;
    if (!de) return {12'(16 << s), 12'(128 << s), 12'(128 << s)};
    y  = ((66 * r + 129 * g + 25 * b + 128) >>> 8) + (16 << s);
    cb = ((-38 * r - 74 * g + 112 * b + 128) >>> 8) + (128 << s);
    cr = ((112 * r - 94 * g - 18 * b + 128) >>> 8) + (128 << s);
    if (y < (16 << s)) y = 16 << s;
    if (y > (235 << s)) y = 235 << s;
    if (cb < (16 << s)) cb = 16 << s;
    if (cb > (240 << s)) cb = 240 << s;
    if (cr < (16 << s)) cr = 16 << s;
    if (cr > (240 << s)) cr = 240 << s;
    return {12'(y), 12'(cb), 12'(cr)};
  endfunction

  // Drives one beat at the current negedge; expected values come from the model
  // unless fixed constants are supplied.
  task automatic drive(input logic [47:0] d8, input logic [59:0] d10, input logic [1:0] h,
                       input logic [1:0] v, input logic [1:0] de, input bit use_fixed,
                       input logic [47:0] f8, input logic [59:0] f10);
    exp_t e;
    logic [35:0] t;
    din8 = d8; din10 = d10; h_in = h; v_in = v; de_in = de;
    e.h = h; e.v = v; e.de = de; e.due = cyc + 3;
    for (int k = 0; k < 2; k++) begin
      t = ref_lane(8, int'(d8[24*k+16 +: 8]), int'(d8[24*k+8 +: 8]), int'(d8[24*k +: 8]), de[k]);
      e.e8[24*k +: 24] = {t[31:24], t[19:12], t[7:0]};
      t = ref_lane(10, int'(d10[30*k+20 +: 10]), int'(d10[30*k+10 +: 10]),
                   int'(d10[30*k +: 10]), de[k]);
      e.e10[30*k +: 30] = {t[33:24], t[21:12], t[9:0]};
    end
    if (use_fixed) begin
      e.e8 = f8;
      e.e10 = f10;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        if (e.due < cyc) begin
          checks++;
          errors++;
          $display("FAIL beat_lost due=%0d now=%0d", e.due, cyc);
        end else begin
          chk("beat", {8'h0, dout8, dout10, h8, v8, de8, h10, v10, de10},
              {8'h0, e.e8, e.e10, e.h, e.v, e.de, e.h, e.v, e.de});
          $display("beat cyc=%0d y8=%h y10=%h sync=%b%b%b", cyc, dout8, dout10, h8, v8, de8);
        end
      end
    end
  end

  localparam logic [23:0] W8 = 24'hFFFFFF, K8 = 24'h000000, R8 = 24'hFF0000, B8 = 24'h0000FF;
  localparam logic [23:0] EW8 = {8'd235, 8'd128, 8'd128}, EK8 = {8'd16, 8'd128, 8'd128};
  localparam logic [23:0] ER8 = {8'd82, 8'd90, 8'd240}, EB8 = {8'd41, 8'd240, 8'd110};
  localparam logic [29:0] W10 = {10'd1023, 10'd1023, 10'd1023}, K10 = 30'd0;
  localparam logic [29:0] EW10 = {10'd940, 10'd512, 10'd512}, EK10 = {10'd64, 10'd512, 10'd512};

  initial begin
    // Reset held with random inputs: every output must stay zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_hold", {8'h0, dout8, dout10, h8, v8, de8, h10, v10, de10}, 128'h0);
      din8 = {$urandom, $urandom}; din10 = {$urandom, $urandom};
      h_in = 2'($urandom); v_in = 2'($urandom); de_in = 2'($urandom);
    end
    rst_n = 1'b1;

    drive({W8, W8}, {W10, W10}, 2'b00, 2'b00, 2'b11, 1, {EW8, EW8}, {EW10, EW10});
    @(negedge clk);
    drive({K8, K8}, {K10, K10}, 2'b00, 2'b00, 2'b11, 1, {EK8, EK8}, {EK10, EK10});
    @(negedge clk);
    drive({R8, R8}, {K10, K10}, 2'b00, 2'b00, 2'b11, 1, {ER8, ER8}, {EK10, EK10});
    @(negedge clk);
    drive({B8, B8}, {W10, K10}, 2'b00, 2'b00, 2'b11, 1, {EB8, EB8}, {EW10, EK10});
    @(negedge clk);
    drive({B8, R8}, {K10, W10}, 2'b00, 2'b00, 2'b11, 1, {EB8, ER8}, {EK10, EW10});
    @(negedge clk);
    drive({R8, B8}, {K10, K10}, 2'b00, 2'b00, 2'b11, 1, {ER8, EB8}, {EK10, EK10});

    // Single-cycle sync pulses with de toggling every beat.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive({$urandom, $urandom}, {$urandom, $urandom}, {1'b0, i == 2}, {i == 4, 1'b0},
            (i % 2) ? 2'b11 : 2'b00, 0, '0, '0);
    end

    // Back-to-back random stream, mostly active video.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      drive({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom), 2'($urandom),
            {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)}, 0, '0, '0);
    end

    // Reset mid-line, between edges: outputs must clear before the next edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 chk("rst_async", {8'h0, dout8, dout10, h8, v8, de8, h10, v10, de10}, 128'h0);
    @(negedge clk);
    chk("rst_mid_hold", {8'h0, dout8, dout10, h8, v8, de8, h10, v10, de10}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, 2'($urandom), 2'($urandom),
            2'b11, 0, '0, '0);
      @(negedge clk);
    end
    de_in = 2'b00;
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
